// File: rtl/fifo_read_ctrl.sv
// Read-side AFIFO controller: gray read pointer, empty flag, and a 2-entry prefetch skid in rclk.
// Optional storage-level output is enabled by defining FIFO_RD_LEVEL_EN.
module fifo_read_ctrl #(
  parameter int DATA_WIDTH = 51,
  parameter int ADDR_SIZE  = 1
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [ADDR_SIZE:0]    rq2_wptr,
  output logic [ADDR_SIZE:0]    rptr,
  output logic                  rempty,
  output logic [ADDR_SIZE-1:0]  raddr,
  output logic                  rclken,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [ADDR_SIZE:0]    rlevel
`endif
);

  logic [ADDR_SIZE:0]    rbin_q, rbin_d;
  logic [ADDR_SIZE:0]    rptr_q, rgray_d;
  logic                  rempty_q, rempty_d;
  logic                  inflight_q;
  logic [1:0]            occ_q, occ_d;
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  logic [DATA_WIDTH-1:0] skid_q [2];
  logic                  pop;
  logic                  issue;
  logic [2:0]            credit;

  // Reads in flight plus buffered words must stay below the skid depth,
  // counting the word leaving this cycle as already gone.
  always_comb begin
    pop      = (occ_q != 2'd0) & out_ready;
    credit   = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue    = ~rempty_q & (credit < 3'd2);
    rbin_d   = rbin_q + {{ADDR_SIZE{1'b0}}, issue};
    rgray_d  = (rbin_d >> 1) ^ rbin_d;
    rempty_d = (rgray_d == rq2_wptr);
    occ_d    = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    head_d   = head_q ^ pop;
    tail_d   = tail_q ^ inflight_q;
  end

  // Pointer / issue stage
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_q     <= '0;
      rptr_q     <= '0;
      rempty_q   <= 1'b1;
      inflight_q <= 1'b0;
    end else begin
      rbin_q     <= rbin_d;
      rptr_q     <= rgray_d;
      rempty_q   <= rempty_d;
      inflight_q <= issue;
    end
  end

  // Skid stage: a reset drops the word returning from memory because inflight_q clears
  always_ff @(posedge rclk) begin
    if (rrst) begin
      occ_q  <= 2'd0;
      head_q <= 1'b0;
      tail_q <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge rclk) begin
    if (inflight_q) skid_q[tail_q] <= mem_rdata;
  end

  assign rptr      = rptr_q;
  assign rempty    = rempty_q;
  assign raddr     = rbin_q[ADDR_SIZE-1:0];
  assign rclken    = issue;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = out_valid ? skid_q[head_q] : '0;

`ifdef FIFO_RD_LEVEL_EN
  function automatic logic [ADDR_SIZE:0] gray2bin(input logic [ADDR_SIZE:0] g);
    logic [ADDR_SIZE:0] b;
    b[ADDR_SIZE] = g[ADDR_SIZE];
    for (int i = ADDR_SIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [ADDR_SIZE:0] rlevel_q;

  always_ff @(posedge rclk) begin
    if (rrst) rlevel_q <= '0;
    else      rlevel_q <= gray2bin(rq2_wptr) - rbin_d;
  end

  assign rlevel = rlevel_q;
`endif

endmodule
